// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: core-side status/request inputs and CSR write / PC redirect outputs.
// master = core/controller side, slave = trap_sequencer.
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            is_mret;
  logic [XLEN-1:0] pc_cur;
  logic            irq_timer;
  logic            irq_ext;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            stall;
  logic            csr_wr_en;
  logic [11:0]     csr_wr_addr;
  logic [XLEN-1:0] csr_wr_data;
  logic            pc_redirect;
  logic [XLEN-1:0] pc_target;
  logic            trap_taken;

  modport master (
    output instr_valid, is_mret, pc_cur, irq_timer, irq_ext, mstatus, mie, mtvec, mepc,
    input  stall, csr_wr_en, csr_wr_addr, csr_wr_data, pc_redirect, pc_target, trap_taken
  );

  modport slave (
    input  instr_valid, is_mret, pc_cur, irq_timer, irq_ext, mstatus, mie, mtvec, mepc,
    output stall, csr_wr_en, csr_wr_addr, csr_wr_data, pc_redirect, pc_target, trap_taken
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET exit sequencer: one CSR write per cycle, then PC redirect.
// Optional macro TRAP_VECTORED_EN enables vectored mtvec mode (mtvec[1:0]==2'b01).
//  state       | meaning
//  IDLE        | watch for enabled IRQ or MRET; stall combinationally in the detect cycle
//  SAVE_EPC    | write mepc with latched PC
//  SAVE_CAUSE  | write mcause with latched cause
//  UPD_STATUS  | write mstatus for trap entry, compute trap vector
//  MRET_STATUS | write mstatus for MRET, target = mepc
//  REDIRECT    | pulse pc_redirect to pc_target
module trap_sequencer #(
  parameter int          XLEN         = 32,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input logic            clk,
  input logic            rst_n,
  trap_sequencer_if.slave bus
);
  localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

  typedef enum logic [2:0] {
    IDLE, SAVE_EPC, SAVE_CAUSE, UPD_STATUS, MRET_STATUS, REDIRECT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            ext_en, tmr_en, irq_take, mret_take;
  logic [XLEN-1:0] status_entry, status_mret, vec_base, trap_vec;

  assign ext_en = bus.irq_ext & bus.mie[11];
  assign tmr_en = bus.irq_timer & bus.mie[7];

  // Gated by rst_n so the combinational detect outputs also read 0 while in reset.
  assign irq_take  = rst_n && (state_q == IDLE) && bus.instr_valid && bus.mstatus[3]
                     && (ext_en || tmr_en);
  assign mret_take = rst_n && (state_q == IDLE) && bus.instr_valid && bus.is_mret && !irq_take;

  always_comb begin
    status_entry        = bus.mstatus;
    status_entry[7]     = bus.mstatus[3];
    status_entry[3]     = 1'b0;
    status_entry[12:11] = 2'b11;
    status_mret         = bus.mstatus;
    status_mret[3]      = bus.mstatus[7];
    status_mret[7]      = 1'b1;
    status_mret[12:11]  = 2'b11;
  end

  assign vec_base = {bus.mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign trap_vec = (bus.mtvec[1:0] == 2'b01) ? vec_base + {cause_q[XLEN-3:0], 2'b00} : vec_base;
`else
  assign trap_vec = vec_base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    epc_d           = epc_q;
    cause_d         = cause_q;
    target_d        = target_q;
    bus.stall       = 1'b0;
    bus.csr_wr_en   = 1'b0;
    bus.csr_wr_addr = '0;
    bus.csr_wr_data = '0;
    bus.pc_redirect = 1'b0;
    bus.trap_taken  = 1'b0;
    case (state_q)
      IDLE: begin
        if (irq_take) begin
          epc_d          = bus.pc_cur;
          cause_d        = ext_en ? CAUSE_EXT : CAUSE_TMR;
          bus.trap_taken = 1'b1;
          bus.stall      = 1'b1;
          state_d        = SAVE_EPC;
        end else if (mret_take) begin
          bus.stall = 1'b1;
          state_d   = MRET_STATUS;
        end
      end
      SAVE_EPC: begin
        bus.stall       = 1'b1;
        bus.csr_wr_en   = 1'b1;
        bus.csr_wr_addr = MEPC_ADDR;
        bus.csr_wr_data = epc_q;
        state_d         = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        bus.stall       = 1'b1;
        bus.csr_wr_en   = 1'b1;
        bus.csr_wr_addr = MCAUSE_ADDR;
        bus.csr_wr_data = cause_q;
        state_d         = UPD_STATUS;
      end
      UPD_STATUS: begin
        bus.stall       = 1'b1;
        bus.csr_wr_en   = 1'b1;
        bus.csr_wr_addr = MSTATUS_ADDR;
        bus.csr_wr_data = status_entry;
        target_d        = trap_vec;
        state_d         = REDIRECT;
      end
      MRET_STATUS: begin
        bus.stall       = 1'b1;
        bus.csr_wr_en   = 1'b1;
        bus.csr_wr_addr = MSTATUS_ADDR;
        bus.csr_wr_data = status_mret;
        target_d        = bus.mepc;
        state_d         = REDIRECT;
      end
      REDIRECT: begin
        bus.stall       = 1'b1;
        bus.pc_redirect = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc_target = target_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized scoreboard bench for trap_sequencer: expected CSR writes and redirects are
// queued by a reference model at issue time and popped by an independent monitor.
module tb_trap_sequencer;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(32)) bus ();
  trap_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int exp_taken_total = 0;
  int got_taken_total = 0;

  logic [11:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_tgt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] tvec, input bit ext);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (tvec[1:0] == 2'b01) return base + (ext ? 32'h2C : 32'h1C);
`endif
    return base;
  endfunction

  function automatic logic [31:0] ref_entry_status(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] ref_mret_status(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Monitor: consumes expected events whenever the DUT presents a write or redirect.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.csr_wr_en) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_csr_write: got addr %h data %h expected none",
                   bus.csr_wr_addr, bus.csr_wr_data);
        end else begin
          check("csr_addr", {20'b0, bus.csr_wr_addr}, {20'b0, exp_addr_q.pop_front()});
          check("csr_data", bus.csr_wr_data, exp_data_q.pop_front());
        end
      end else begin
        check("csr_idle_bus", {20'b0, bus.csr_wr_addr} | bus.csr_wr_data, 32'h0);
      end
      if (bus.pc_redirect) begin
        checks++;
        if (exp_tgt_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_redirect: got %h expected none", bus.pc_target);
        end else begin
          check("pc_target", bus.pc_target, exp_tgt_q.pop_front());
        end
      end
      if (bus.trap_taken) got_taken_total++;
    end
  end

  task automatic clear_inputs();
    bus.instr_valid = 0; bus.is_mret = 0; bus.irq_timer = 0; bus.irq_ext = 0;
    bus.pc_cur = 0; bus.mstatus = 0; bus.mie = 0; bus.mtvec = 0; bus.mepc = 0;
  endtask

  task automatic txn(input logic v, input logic mret, input logic tmr, input logic ext,
                     input logic [31:0] ms, input logic [31:0] ie, input logic [31:0] tvec,
                     input logic [31:0] epc, input logic [31:0] pc, input logic drop_irq);
    bit take, ret, ext_win;
    int exp_stall, n;
    logic [31:0] tgt;
    @(posedge clk); #1;
    bus.instr_valid = v; bus.is_mret = mret; bus.irq_timer = tmr; bus.irq_ext = ext;
    bus.mstatus = ms; bus.mie = ie; bus.mtvec = tvec; bus.mepc = epc; bus.pc_cur = pc;
    ext_win = ext && ie[11];
    take = v && ms[3] && (ext_win || (tmr && ie[7]));
    ret  = v && mret && !take;
    exp_stall = 0;
    tgt = 0;
    if (take) begin
      exp_addr_q.push_back(A_MEPC);    exp_data_q.push_back(pc);
      exp_addr_q.push_back(A_MCAUSE);  exp_data_q.push_back(ext_win ? 32'h8000_000B : 32'h8000_0007);
      exp_addr_q.push_back(A_MSTATUS); exp_data_q.push_back(ref_entry_status(ms));
      tgt = ref_target(tvec, ext_win);
      exp_tgt_q.push_back(tgt);
      exp_taken_total++;
      exp_stall = 5;
    end else if (ret) begin
      exp_addr_q.push_back(A_MSTATUS); exp_data_q.push_back(ref_mret_status(ms));
      tgt = epc;
      exp_tgt_q.push_back(tgt);
      exp_stall = 3;
    end
    @(negedge clk);
    check("trap_taken_detect", {31'b0, bus.trap_taken}, {31'b0, take});
    n = bus.stall ? 1 : 0;
    @(posedge clk); #1;
    bus.instr_valid = 0; bus.is_mret = 0;
    if (drop_irq) begin bus.irq_timer = 0; bus.irq_ext = 0; end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.stall) n++;
      else break;
    end
    check("stall_cycles", n, exp_stall);
    check("pending_writes", exp_addr_q.size(), 0);
    check("pending_redirects", exp_tgt_q.size(), 0);
    if (take || ret) check("pc_target_hold", bus.pc_target, tgt);
    bus.irq_timer = 0; bus.irq_ext = 0;
  endtask

  initial begin
    int t0;
    clear_inputs();
    rst_n = 0;
    #12;
    check("reset_stall", {31'b0, bus.stall}, 0);
    check("reset_target", bus.pc_target, 0);
    check("reset_csr_en", {31'b0, bus.csr_wr_en}, 0);
    @(negedge clk); rst_n = 1;

    // Timer trap, direct mode
    txn(1, 0, 1, 0, 32'h8, 32'h80, 32'h2000, 32'h0, 32'h100, 0);
    // Both IRQs pending: external wins, exactly one trap_taken pulse
    t0 = got_taken_total;
    txn(1, 0, 1, 1, 32'h8, 32'h880, 32'h2000, 32'h0, 32'h200, 1);
    check("trap_taken_once", got_taken_total - t0, 1);
    // MRET
    txn(1, 1, 0, 0, 32'h1880, 32'h0, 32'h2000, 32'h104, 32'h104, 0);
    // Globally disabled, then locally disabled: nothing happens
    txn(1, 0, 1, 1, 32'h0, 32'h880, 32'h2000, 32'h0, 32'h300, 0);
    txn(1, 0, 1, 1, 32'h8, 32'h0, 32'h2000, 32'h0, 32'h300, 0);
    // MRET and IRQ together: trap path, MRET address saved
    txn(1, 1, 1, 0, 32'h8, 32'h80, 32'h2000, 32'h500, 32'h400, 0);
    // Vectored-capable mtvec with external IRQ
    txn(1, 0, 0, 1, 32'h8, 32'h800, 32'h2001, 32'h0, 32'h600, 1);
    // instr_valid low: IRQ ignored
    txn(0, 1, 1, 1, 32'h88, 32'h880, 32'h2000, 32'h0, 32'h700, 0);

    // Reset asserted during SAVE_CAUSE
    @(posedge clk); #1;
    bus.instr_valid = 1; bus.irq_timer = 1; bus.mstatus = 32'h8; bus.mie = 32'h80;
    bus.mtvec = 32'h3000; bus.pc_cur = 32'h800;
    exp_addr_q.push_back(A_MEPC); exp_data_q.push_back(32'h800);
    exp_taken_total++;
    @(posedge clk); #1; bus.instr_valid = 0;
    @(posedge clk); #2;
    rst_n = 0;
    bus.instr_valid = 1;
    #1;
    check("rst_mid_csr_en", {31'b0, bus.csr_wr_en}, 0);
    check("rst_mid_csr_bus", {20'b0, bus.csr_wr_addr} | bus.csr_wr_data, 0);
    check("rst_mid_stall", {31'b0, bus.stall}, 0);
    check("rst_mid_redirect", {31'b0, bus.pc_redirect}, 0);
    check("rst_mid_trap_taken", {31'b0, bus.trap_taken}, 0);
    check("rst_mid_target", bus.pc_target, 0);
    check("rst_mid_epc_written", exp_addr_q.size(), 0);
    exp_addr_q.delete(); exp_data_q.delete(); exp_tgt_q.delete();
    clear_inputs();
    #20;
    @(negedge clk); rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_idle_stall", {31'b0, bus.stall}, 0);
    end

    for (int k = 0; k < 60; k++) begin
      logic [31:0] ms, ie, tv;
      ms = $urandom & 32'hFFFF_E777;
      ms[3] = ($urandom_range(0, 3) != 0);
      ms[7] = $urandom_range(0, 1);
      ie = 32'h0;
      ie[7] = $urandom_range(0, 1);
      ie[11] = $urandom_range(0, 1);
      tv = {$urandom, 2'b00} | 32'($urandom_range(0, 3));
      txn($urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), ms, ie, tv, {$urandom, 2'b00}, {$urandom, 2'b00},
          $urandom_range(0, 1));
    end

    check("trap_taken_total", got_taken_total, exp_taken_total);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
